// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: 64-byte line reads (8 x 64-bit beats after LATENCY) and line writes.
// Optional macro SYSBUS_MMIO_HOLE_EN: lines in 0xA0000-0xFFFFF read as all-ones and drop writes.
module sysbus_mem_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  output logic        reqack,
  output logic        respcyc,
  output logic [63:0] resp,
  output logic [12:0] resptag,
  input  logic        respack
);

  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int LINE_W = ADDR_W - 3;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [3:0] TYPE_MEMORY = 4'h1;

  typedef enum logic [1:0] {IDLE, WAIT, RBURST, WDATA} state_t;

  state_t state, state_nxt;

  logic [63:0]       mem [MEM_WORDS];
  logic [LINE_W-1:0] line;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        beat;
  logic              hole;
  logic              in_hole;

  logic       accept;
  logic       cmd_mem;
  logic       cmd_read;
  logic       beat_done;
  logic       wr_beat;
  logic       last_beat;
  logic       load_resp;
  logic [2:0] rd_beat;

  // The command stays on req through the ack cycle, so neither a new accept
  // nor a write beat may be taken while reqack is high.
  assign accept    = (state == IDLE) && reqcyc && !reqack;
  assign cmd_mem   = (reqtag[11:8] == TYPE_MEMORY);
  assign cmd_read  = reqtag[12];
  assign beat_done = (state == RBURST) && respcyc && respack;
  assign wr_beat   = (state == WDATA) && reqcyc && !reqack;
  assign last_beat = (beat == 3'd7);
  assign load_resp = ((state == WAIT) && (cnt == '0)) || (beat_done && !last_beat);
  assign rd_beat   = (state == WAIT) ? 3'd0 : beat + 3'd1;

`ifdef SYSBUS_MMIO_HOLE_EN
  assign in_hole = (req[63:20] == '0) && (req[19:6] >= 14'h2800);
`else
  assign in_hole = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && cmd_mem) state_nxt = cmd_read ? WAIT : WDATA;
      WAIT:    if (cnt == '0) state_nxt = RBURST;
      RBURST:  if (beat_done && last_beat) state_nxt = IDLE;
      WDATA:   if (wr_beat && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      reqack  <= 1'b0;
      respcyc <= 1'b0;
      resp    <= '0;
      resptag <= '0;
      line    <= '0;
      cnt     <= '0;
      beat    <= '0;
      hole    <= 1'b0;
    end else begin
      reqack  <= accept;
      respcyc <= (state_nxt == RBURST);
      if (accept) begin
        line    <= req[ADDR_W+2:6];
        resptag <= reqtag;
        cnt     <= CNT_W'(LATENCY - 1);
        beat    <= '0;
        hole    <= in_hole;
      end
      if ((state == WAIT) && (cnt != '0)) cnt <= cnt - 1'b1;
      if (beat_done || wr_beat) beat <= beat + 3'd1;
      // Registered read: the next beat is fetched on the edge that retires the current one.
      if (load_resp) resp <= hole ? '1 : mem[{line, rd_beat}];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_beat && !hole) mem[{line, beat}] <= req;
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: transaction-level memory model plus a per-cycle compare process.
module tb_sysbus_mem_responder;
  localparam int MEM_WORDS = 4096;
  localparam int LATENCY   = 4;
`ifdef SYSBUS_MMIO_HOLE_EN
  localparam bit HOLE_EN = 1'b1;
`else
  localparam bit HOLE_EN = 1'b0;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respack;

  sysbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
    .reqack(reqack), .respcyc(respcyc), .resp(resp), .resptag(resptag), .respack(respack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] model_mem [MEM_WORDS];
  logic [63:0] expq [$];
  logic [12:0] exp_tag;
  int          first_cyc;
  int          exp_ack_cyc = -1;
  int          last_beat_cyc = -1;
  bit          check_en = 1'b0;
  bit          waiting_req = 1'b0;
  bit          exp_rc;
  logic [63:0] got [8];
  int          got_cyc [8];
  int          stall_left [8];

  task automatic chk(input string nm, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, actual, expected, cyc);
    end
  endtask

  function automatic int widx(input logic [63:0] a, input int b);
    logic [63:0] line_no;
    line_no = (a >> 6) % 64'(MEM_WORDS / 8);
    return int'(line_no) * 8 + b;
  endfunction

  function automatic bit in_hole(input logic [63:0] a);
    return HOLE_EN && (a >= 64'hA0000) && (a < 64'h100000);
  endfunction

  // Per-cycle compare against the expected-beat queue.
  always @(negedge clk) begin
    if (check_en) begin
      chk("reqack", 64'(reqack), 64'(cyc == exp_ack_cyc));
      exp_rc = (expq.size() > 0) && (cyc >= first_cyc);
      chk("respcyc", 64'(respcyc), 64'(exp_rc));
      if (exp_rc && respcyc) begin
        chk("resp", resp, expq[0]);
        chk("resptag", 64'(resptag), 64'(exp_tag));
        if (respack) begin
          got[8 - expq.size()]     = resp;
          got_cyc[8 - expq.size()] = cyc;
          void'(expq.pop_front());
          if (expq.size() == 0) begin
            last_beat_cyc = cyc;
            if (waiting_req) exp_ack_cyc = cyc + 2;
          end
        end
      end
      if (!reset) expq.delete();
    end
  end

  // Initiator response side: respack follows respcyc except on programmed stall cycles.
  initial begin
    respack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (respcyc && expq.size() > 0 && stall_left[8 - expq.size()] > 0) begin
        respack = 1'b0;
        stall_left[8 - expq.size()]--;
      end else begin
        respack = respcyc;
      end
    end
  end

  task automatic issue(input logic [63:0] a, input logic [12:0] t, input bit expect_now,
                       output int ic, output int ac);
    @(posedge clk);
    #1;
    req = a;
    reqtag = t;
    reqcyc = 1'b1;
    ic = cyc;
    if (expect_now) exp_ack_cyc = cyc + 1;
    ac = -1;
    for (int i = 0; i < 200 && ac < 0; i++) begin
      @(posedge clk);
      #1;
      if (reqack) ac = cyc;
    end
    if (ac < 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: no reqack for addr %h, required within 200 cycles", a);
    end
  endtask

  task automatic do_read(input logic [63:0] a, input logic [7:0] id, input bit expect_now,
                         output int ic, output int ac);
    logic [12:0] t;
    t = {1'b1, 4'h1, id};
    issue(a, t, expect_now, ic, ac);
    for (int b = 0; b < 8; b++) begin
      got[b] = '0;
      got_cyc[b] = -1;
    end
    exp_tag = t;
    first_cyc = ac + LATENCY;
    for (int b = 0; b < 8; b++) expq.push_back(in_hole(a) ? ONES : model_mem[widx(a, b)]);
    @(posedge clk);
    #1;
    reqcyc = 1'b0;
  endtask

  task automatic wait_burst();
    for (int i = 0; i < 300 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL burst_timeout: %0d beats outstanding, required 0", expq.size());
      expq.delete();
    end
  endtask

  task automatic do_write(input logic [63:0] a, input logic [7:0] id, input logic [63:0] base,
                          input int gap_after);
    int ic;
    int ac;
    issue(a, {1'b0, 4'h1, id}, 1'b1, ic, ac);
    for (int b = 0; b < 8; b++) begin
      @(posedge clk);
      #1;
      req = base + 64'(b);
      reqcyc = 1'b1;
      if (!in_hole(a)) model_mem[widx(a, b)] = base + 64'(b);
      if (b == gap_after) begin
        @(posedge clk);
        #1;
        reqcyc = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    reqcyc = 1'b0;
  endtask

  initial begin
    int ic;
    int ac;
    reset = 1'b0;
    reqcyc = 1'b0;
    req = '0;
    reqtag = '0;
    for (int b = 0; b < 8; b++) stall_left[b] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reqack", 64'(reqack), 64'd0);
    chk("rst_respcyc", 64'(respcyc), 64'd0);
    chk("rst_resp", resp, 64'd0);
    chk("rst_resptag", 64'(resptag), 64'd0);
    reset = 1'b1;
    check_en = 1'b1;

    // Preload line 0, then the basic read with respack tied to respcyc.
    do_write(64'h0, 8'h01, 64'h1000, -1);
    do_read(64'h3, 8'h11, 1'b1, ic, ac);
    wait_burst();
    chk("t1_ack_lat", 64'(ac - ic), 64'd1);
    chk("t1_first_beat_cyc", 64'(got_cyc[0] - ic), 64'd5);
    chk("t1_last_beat_cyc", 64'(got_cyc[7] - ic), 64'd12);
    chk("t1_beat0", got[0], 64'h1000);
    chk("t1_beat7", got[7], 64'h1007);

    // Stalls of 3 cycles on beats 2 and 5.
    stall_left[2] = 3;
    stall_left[5] = 3;
    do_read(64'h3, 8'h12, 1'b1, ic, ac);
    wait_burst();
    chk("t2_last_beat_cyc", 64'(got_cyc[7] - ic), 64'd18);
    chk("t2_beat2", got[2], 64'h1002);
    chk("t2_beat5", got[5], 64'h1005);

    // Non-memory type: acked once, no response.
    issue(64'h80, {1'b1, 4'h2, 8'h33}, 1'b1, ic, ac);
    chk("nonmem_ack_lat", 64'(ac - ic), 64'd1);
    @(posedge clk);
    #1;
    reqcyc = 1'b0;
    repeat (LATENCY + 10) @(posedge clk);

    // Write with a one-cycle gap after beat 3, then read back.
    do_write(64'h40, 8'h02, 64'hA0, 3);
    do_read(64'h40, 8'h13, 1'b1, ic, ac);
    wait_burst();
    chk("t3_beat0", got[0], 64'hA0);
    chk("t3_beat4", got[4], 64'hA4);
    chk("t3_beat7", got[7], 64'hA7);

    // Second request raised during a burst.
    do_read(64'h0, 8'h14, 1'b1, ic, ac);
    for (int i = 0; i < 50 && expq.size() > 5; i++) begin
      @(posedge clk);
      #1;
    end
    waiting_req = 1'b1;
    do_read(64'h40, 8'h15, 1'b0, ic, ac);
    waiting_req = 1'b0;
    chk("t4_ack_after_burst", 64'(ac - last_beat_cyc), 64'd2);
    wait_burst();
    chk("t4_beat0", got[0], 64'hA0);
    chk("t4_beat7", got[7], 64'hA7);

    // Reset while beat 4 is on the bus.
    do_read(64'h0, 8'h16, 1'b1, ic, ac);
    for (int i = 0; i < 50 && expq.size() > 4; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_respcyc_after_rst", 64'(respcyc), 64'd0);
    chk("t5_reqack_after_rst", 64'(reqack), 64'd0);
    reset = 1'b1;
    do_read(64'h0, 8'h17, 1'b1, ic, ac);
    wait_burst();
    chk("t5_beat0", got[0], 64'h1000);
    chk("t5_beat4", got[4], 64'h1004);
    chk("t5_beat7", got[7], 64'h1007);

    // MMIO hole region (aliases lines 0 and 1 when the hole is disabled).
    do_read(64'hA0000, 8'h18, 1'b1, ic, ac);
    wait_burst();
    chk("t6_hole_read", got[0], HOLE_EN ? ONES : 64'h1000);
    do_write(64'hA0040, 8'h03, 64'hB0, -1);
    do_read(64'hA0040, 8'h19, 1'b1, ic, ac);
    wait_burst();
    chk("t6_hole_write_read", got[3], HOLE_EN ? ONES : 64'hB3);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
